// File: rtl/mini_bus_ctrl.sv
// Registered CPU data-bus controller: decodes the address top nibble to one slave,
// runs a select/ack handshake with timeout, and returns a one-cycle completion pulse.
module mini_bus_ctrl #(
    parameter int                        NUM_SLAVES = 5,
    parameter int                        DATA_W     = 32,
    parameter int                        ADDR_W     = 32,
    parameter logic [4*NUM_SLAVES-1:0]   SLAVE_TAGS = {4'hC, 4'h3, 4'h2, 4'h1, 4'h0},
    parameter int                        TIMEOUT    = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cpu_req,
    input  logic                         cpu_wen,
    input  logic [ADDR_W-1:0]            cpu_addr,
    input  logic [DATA_W-1:0]            cpu_wdata,
    input  logic [DATA_W/8-1:0]          cpu_wstrb,
    output logic                         cpu_ready,
    output logic                         cpu_rvalid,
    output logic [DATA_W-1:0]            cpu_rdata,
    output logic                         cpu_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic                         s_wen,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic                    wen_q, wen_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W/8-1:0]     wstrb_q, wstrb_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [7:0]              cnt_q, cnt_d;

    logic                    hit;
    logic [NUM_SLAVES-1:0]   hit_sel;
    logic                    ack_hit;
    logic [DATA_W-1:0]       ack_data;

    // Scan from the top index down so the lowest matching slice wins.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (SLAVE_TAGS[4*i +: 4] == cpu_addr[ADDR_W-1 -: 4]) begin
                hit        = 1'b1;
                hit_sel    = '0;
                hit_sel[i] = 1'b1;
            end
        end
    end

    always_comb begin
        ack_data = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) begin
                ack_data = ack_data | s_rdata[i*DATA_W +: DATA_W];
            end
        end
        ack_hit = |(s_ack & sel_q);
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    wen_d   = cpu_wen;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    wstrb_d = cpu_wen ? cpu_wstrb : '0;
                    cnt_d   = '0;
                    if (hit) begin
                        sel_d   = hit_sel;
                        state_d = ACCESS;
                    end else begin
                        rdata_d = '0;
                        state_d = ERR;
                    end
                end
            end
            ACCESS: begin
                // An ack on the final allowed cycle still completes normally.
                if (ack_hit) begin
                    rdata_d = wen_q ? '0 : ack_data;
                    sel_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == TO_LAST) begin
                        rdata_d = '0;
                        sel_d   = '0;
                        state_d = ERR;
                    end
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cpu_ready  = (state_q == IDLE);
    assign cpu_rvalid = (state_q == RESP) || (state_q == ERR);
    assign cpu_err    = (state_q == ERR);
    assign cpu_rdata  = rdata_q;
    assign s_sel      = sel_q;
    assign s_wen      = wen_q;
    assign s_addr     = addr_q;
    assign s_wdata    = wdata_q;
    assign s_wstrb    = wstrb_q;

endmodule

// File: doc/mini_bus_ctrl.md
Name: mini_bus_ctrl

Overview:
Parametrised, registered successor to the combinational CPU data-memory decoder. It accepts one CPU data request at a time and decodes the address top nibble against a per-slave tag table. It drives a single-slave select with a ready/ack handshake, so slow slaves (SRAM, flash, device IO) can insert wait states. It returns read data or an error response, and times out on slaves that never acknowledge. It sits between the CPU data port and the RAM/VRAM/palette/ROM/device-IO slaves.

Parameters:
NUM_SLAVES, 5, number of slave ports (1..16)
DATA_W, 32, data width; a multiple of 8
ADDR_W, 32, address width; must be at least 4
SLAVE_TAGS, {4'hC,4'h3,4'h2,4'h1,4'h0}, packed 4*NUM_SLAVES; slave i owns addresses whose addr[ADDR_W-1:ADDR_W-4] equals tag slice i
TIMEOUT, 15, maximum ACCESS cycles without ack before an error response (1..255)

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
cpu_req  input  1  request valid
cpu_wen  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  byte address
cpu_wdata  input  DATA_W  write data
cpu_wstrb  input  DATA_W/8  byte enables for writes
cpu_ready  output  1  controller can accept a request this cycle
cpu_rvalid  output  1  one-cycle completion pulse (reads and writes)
cpu_rdata  output  DATA_W  read data, valid while cpu_rvalid
cpu_err  output  1  unmapped address or timeout, valid while cpu_rvalid
s_sel  output  NUM_SLAVES  one-hot slave select
s_wen  output  1  latched write flag
s_addr  output  ADDR_W  latched address
s_wdata  output  DATA_W  latched write data
s_wstrb  output  DATA_W/8  latched strobes; all zeros for reads
s_rdata  input  NUM_SLAVES*DATA_W  slave read data; slave i at slice i
s_ack  input  NUM_SLAVES  slave completion; slave i at bit i

Behaviour:
- States: IDLE, ACCESS, RESP, ERR. All outputs are registered or decoded from state/latches only; there is no combinational path from cpu_* to s_*.
- Reset: state=IDLE, cpu_ready=1, cpu_rvalid=0, cpu_err=0, cpu_rdata=0, s_sel=0, s_wen=0, s_addr=0, s_wdata=0, s_wstrb=0, timeout counter=0.
- IDLE: cpu_ready=1.
  - When cpu_req=1, latch addr, wdata, wen and wstrb (wstrb forced to 0 for reads), and decode.
  - Match found: ACCESS, with s_sel one-hot set from the next cycle.
  - No match: ERR.
  - When cpu_req=0: remain in IDLE.
- Decode: compare the top nibble with each tag slice. If several slices match, the lowest index wins. A hit sets exactly one s_sel bit.
- ACCESS:
  - cpu_ready=0; s_sel and the latched s_* fields are held stable.
  - Counter starts at 0 on entry and increments each cycle that s_ack[selected]=0.
  - s_ack of the selected slave: capture its s_rdata slice (zero for writes) into cpu_rdata, clear s_sel, go to RESP.
  - Counter reaches TIMEOUT with no ack: clear s_sel, set cpu_rdata=0, go to ERR.
  - Ack bits from unselected slaves are ignored.
- RESP: cpu_rvalid=1 and cpu_err=0 for exactly one cycle, then IDLE.
- ERR: cpu_rvalid=1, cpu_err=1, cpu_rdata=0 for exactly one cycle, then IDLE.
- cpu_rvalid is 0 in every other state. cpu_rdata holds its last value outside the rvalid cycle.
- Latency: request accepted at edge N; s_sel is high during cycle N+1.
  - Zero-wait ack in cycle N+1 gives cpu_rvalid in cycle N+2.
  - Each wait state adds one cycle.
  - Unmapped address gives cpu_rvalid in cycle N+1.
  - Timeout gives cpu_rvalid TIMEOUT+1 cycles after ACCESS entry.
- Back-to-back: cpu_req is sampled only in IDLE. A request presented in RESP or ERR is not accepted until the following IDLE cycle; the CPU holds cpu_req until it sees cpu_ready=1 at an edge.
- Reset mid-operation: abort immediately to reset values. No rvalid is issued for the aborted request. A late slave ack after reset is ignored.
- Ack and timeout in the same cycle: ack wins (RESP, err=0).

Test Plan:
- Zero-wait read: RAM slot (tag 1) acks immediately with data 0x1234_5678 for cpu_addr=0x1000_0010 -> s_sel=5'b00010 for 1 cycle; cpu_rvalid=1, cpu_rdata=0x1234_5678, err=0, two cycles after acceptance.
- Wait-state write: VRAM (tag 2) acks after 3 cycles; cpu_wdata=0xA5A5_A5A5, wstrb=4'b0011 -> s_sel=5'b00100 for 4 cycles with s_wstrb=0011 held stable; then rvalid pulse with err=0 and cpu_ready=0 throughout.
- Unmapped: cpu_addr=0x5000_0000 -> s_sel stays 0; next cycle cpu_rvalid=1, cpu_err=1, cpu_rdata=0.
- Timeout: device IO (tag C) never acks, TIMEOUT=15 -> s_sel[4] high for 15 cycles then dropped; rvalid with err=1, rdata=0.
- Ack/timeout collision: slave acks exactly on the 15th ACCESS cycle -> err=0 with slave data returned.
- Reset mid-ACCESS with back-to-back traffic: rst asserted during a wait state -> next cycle all outputs at reset values, no rvalid; then two back-to-back reads complete in order with one IDLE cycle between them.
